regwrite_sequencer: RTL and testbench

REGWRITE_SEQUENCER -- requirements
Module: regwrite_sequencer

---
 rtl/regwrite_sequencer.sv | 136 +++++++++++++
 tb/tb_regwrite_sequencer.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_sequencer.sv
// Write-back sequencer: queues register-file writes in a small FIFO.
// Drains one entry per cycle into the register file port and flags hazards.
module regwrite_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_rd,
    input  logic [15:0]              in_data,
    input  logic                     in_wr_r15,
    input  logic [15:0]              in_r15_data,
    input  logic                     rf_hold,
    input  logic                     flush,
    output logic [3:0]               rf_write_reg,
    output logic [15:0]              rf_write_data,
    output logic [15:0]              rf_write_r15,
    output logic [1:0]               rf_reg_write,
    input  logic [3:0]               chk_reg1,
    input  logic [3:0]               chk_reg2,
    output logic                     hazard,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] RW_IDLE   = 2'b00;
    localparam logic [1:0] RW_SINGLE = 2'b01;
    localparam logic [1:0] RW_DUAL   = 2'b10;

    logic [3:0]    rd_q       [DEPTH];
    logic [15:0]   data_q     [DEPTH];
    logic          wr_r15_q   [DEPTH];
    logic [15:0]   r15_data_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          full;
    logic          push;
    logic          pop;
    logic          chk_r15;
    logic [DEPTH-1:0] slot_vld;
    logic [DEPTH-1:0] slot_hit;

    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && !rf_hold && !flush;
    assign count    = count_q;
    assign chk_r15  = (chk_reg1 == 4'd15) || (chk_reg2 == 4'd15);

    // A slot is occupied when its distance from the read pointer is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [AW-1:0] off;
        assign off         = AW'(g) - rd_ptr_q;
        assign slot_vld[g] = ({1'b0, off} < count_q);
        assign slot_hit[g] = slot_vld[g] &&
                             ((rd_q[g] == chk_reg1) ||
                              (rd_q[g] == chk_reg2) ||
                              (wr_r15_q[g] && chk_r15));
    end

    assign hazard = |slot_hit;

    // Next-state for pointers and occupancy; flush clears everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and entry storage; reset wipes all entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]       <= '0;
                data_q[i]     <= '0;
                wr_r15_q[i]   <= 1'b0;
                r15_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                rd_q[wr_ptr_q]       <= in_rd;
                data_q[wr_ptr_q]     <= in_data;
                wr_r15_q[wr_ptr_q]   <= in_wr_r15;
                r15_data_q[wr_ptr_q] <= in_r15_data;
            end
        end
    end

    // Present the head entry to the register file only when it drains.
    always_comb begin
        rf_write_reg  = '0;
        rf_write_data = '0;
        rf_write_r15  = '0;
        rf_reg_write  = RW_IDLE;
        if (pop) begin
            rf_write_reg  = rd_q[rd_ptr_q];
            rf_write_data = data_q[rd_ptr_q];
            if (wr_r15_q[rd_ptr_q]) begin
                rf_reg_write = RW_DUAL;
                rf_write_r15 = r15_data_q[rd_ptr_q];
            end else begin
                rf_reg_write = RW_SINGLE;
            end
        end
    end

endmodule

// File: tb/tb_regwrite_sequencer.sv
// Bench for regwrite_sequencer: directed scenarios plus random traffic
// compared against a queue-based model of the write-back FIFO.
module tb_regwrite_sequencer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] data;
        logic        wr;
        logic [15:0] r15;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rd;
    logic [15:0] in_data;
    logic        in_wr_r15;
    logic [15:0] in_r15_data;
    logic        rf_hold;
    logic        flush;
    logic [3:0]  rf_write_reg;
    logic [15:0] rf_write_data;
    logic [15:0] rf_write_r15;
    logic [1:0]  rf_reg_write;
    logic [3:0]  chk_reg1;
    logic [3:0]  chk_reg2;
    logic        hazard;
    logic [2:0]  count;

    ent_t q[$];
    ent_t dut_log[$];
    int   vectors = 0;
    int   errors  = 0;

    regwrite_sequencer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .in_wr_r15     (in_wr_r15),
        .in_r15_data   (in_r15_data),
        .rf_hold       (rf_hold),
        .flush         (flush),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_write_r15  (rf_write_r15),
        .rf_reg_write  (rf_reg_write),
        .chk_reg1      (chk_reg1),
        .chk_reg2      (chk_reg2),
        .hazard        (hazard),
        .count         (count)
    );

    always #5 clk = ~clk;

    function automatic logic m_hazard();
        logic h = 1'b0;
        foreach (q[i]) begin
            if (q[i].rd == chk_reg1 || q[i].rd == chk_reg2)
                h = 1'b1;
            if (q[i].wr && (chk_reg1 == 15 || chk_reg2 == 15))
                h = 1'b1;
        end
        return h;
    endfunction

    // One clock: model follows the queue rules; DUT writes are logged.
    task automatic tick();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = in_valid && (q.size() < DEPTH) && !flush && !rst;
        do_pop  = (q.size() > 0) && !rf_hold && !flush && !rst;
        e = '{in_rd, in_data, in_wr_r15, in_r15_data};
        if (rf_reg_write != 2'b00)
            dut_log.push_back('{rf_write_reg, rf_write_data,
                                rf_reg_write == 2'b10, rf_write_r15});
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (do_pop)
                void'(q.pop_front());
            if (do_push)
                q.push_back(e);
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_rd       = '0;
        in_data     = '0;
        in_wr_r15   = 1'b0;
        in_r15_data = '0;
        rf_hold     = 1'b0;
        flush       = 1'b0;
        chk_reg1    = '0;
        chk_reg2    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        tick();
        tick();
        vectors++;
        if (count !== 3'd0 || hazard !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: count=%0d hazard=%b ready=%b want 0/0/1",
                     count, hazard, in_ready);
        end
        vectors++;
        if (rf_reg_write !== 2'b00 || rf_write_reg !== 4'd0 ||
            rf_write_data !== 16'd0 || rf_write_r15 !== 16'd0) begin
            errors++;
            $display("FAIL reset_rf: rw=%b reg=%0d data=%h r15=%h want zeros",
                     rf_reg_write, rf_write_reg, rf_write_data, rf_write_r15);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_rd    = 4'd5;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (rf_reg_write !== 2'b01 || rf_write_reg !== 4'd5 ||
            rf_write_data !== 16'h1234 || rf_write_r15 !== 16'd0) begin
            errors++;
            $display("FAIL single_write: rw=%b reg=%0d data=%h r15=%h want 01/5/1234/0",
                     rf_reg_write, rf_write_reg, rf_write_data, rf_write_r15);
        end
        tick();
        vectors++;
        if (rf_reg_write !== 2'b00 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_after: rw=%b count=%0d want 00/0",
                     rf_reg_write, count);
        end
    endtask

    task automatic test_dual();
        rf_hold     = 1'b1;
        in_valid    = 1'b1;
        in_rd       = 4'd3;
        in_data     = 16'hAAAA;
        in_wr_r15   = 1'b1;
        in_r15_data = 16'h0001;
        tick();
        in_valid  = 1'b0;
        in_wr_r15 = 1'b0;
        chk_reg1  = 4'd15;
        chk_reg2  = 4'd0;
        #1;
        vectors++;
        if (hazard !== 1'b1 || rf_reg_write !== 2'b00) begin
            errors++;
            $display("FAIL dual_hazard: hazard=%b rw=%b want 1/00",
                     hazard, rf_reg_write);
        end
        rf_hold = 1'b0;
        #1;
        vectors++;
        if (rf_reg_write !== 2'b10 || rf_write_r15 !== 16'h0001 ||
            rf_write_reg !== 4'd3 || rf_write_data !== 16'hAAAA) begin
            errors++;
            $display("FAIL dual_write: rw=%b reg=%0d data=%h r15=%h want 10/3/aaaa/0001",
                     rf_reg_write, rf_write_reg, rf_write_data, rf_write_r15);
        end
        tick();
        vectors++;
        if (count !== 3'd0 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL dual_after: count=%0d hazard=%b want 0/0",
                     count, hazard);
        end
        chk_reg1 = '0;
    endtask

    task automatic test_fill();
        int cyc;
        bit sent5;
        rf_hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_rd    = 4'(k);
            in_data  = 16'(k * 16'h0111);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready_%0d: ready=%b want 1", k, in_ready);
            end
            tick();
        end
        in_rd   = 4'd5;
        in_data = 16'h0555;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: ready=%b count=%0d want 0/4",
                     in_ready, count);
        end
        tick();
        vectors++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL fill_hold5: count=%0d want 4", count);
        end
        rf_hold = 1'b0;
        dut_log.delete();
        sent5 = 1'b0;
        cyc   = 0;
        while ((!sent5 || count != 0) && cyc < 50) begin
            #1;
            if (in_valid && in_ready)
                sent5 = 1'b1;
            tick();
            if (sent5)
                in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (cyc >= 50 || dut_log.size() != 5) begin
            errors++;
            $display("FAIL fill_drain: cycles=%0d writes=%0d want <50/5",
                     cyc, dut_log.size());
        end
        for (int k = 0; k < 5 && k < dut_log.size(); k++) begin
            vectors++;
            if (dut_log[k].rd !== 4'(k + 1)) begin
                errors++;
                $display("FAIL fill_order_%0d: rd=%0d want %0d",
                         k, dut_log[k].rd, k + 1);
            end
        end
    endtask

    task automatic test_wrap();
        ent_t sent[10];
        int   n = 0;
        int   cyc = 0;
        bit   acc;
        for (int k = 0; k < 10; k++)
            sent[k] = '{4'($urandom), 16'hC000 + 16'(k),
                        1'($urandom), 16'($urandom)};
        dut_log.delete();
        while ((n < 10 || count != 0) && cyc < 200) begin
            rf_hold = ((cyc / 3) % 2) == 1;
            if (n < 10) begin
                in_valid    = 1'b1;
                in_rd       = sent[n].rd;
                in_data     = sent[n].data;
                in_wr_r15   = sent[n].wr;
                in_r15_data = sent[n].r15;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc)
                n++;
            cyc++;
        end
        idle_inputs();
        vectors++;
        if (cyc >= 200 || dut_log.size() != 10 || count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_total: cycles=%0d writes=%0d count=%0d want <200/10/0",
                     cyc, dut_log.size(), count);
        end
        for (int k = 0; k < 10 && k < dut_log.size(); k++) begin
            vectors++;
            if (dut_log[k].rd !== sent[k].rd ||
                dut_log[k].data !== sent[k].data ||
                dut_log[k].wr !== sent[k].wr ||
                dut_log[k].r15 !== (sent[k].wr ? sent[k].r15 : 16'd0)) begin
                errors++;
                $display("FAIL wrap_entry_%0d: rd=%0d data=%h wr=%b r15=%h want %0d/%h/%b",
                         k, dut_log[k].rd, dut_log[k].data, dut_log[k].wr,
                         dut_log[k].r15, sent[k].rd, sent[k].data, sent[k].wr);
            end
        end
    endtask

    task automatic load3(input logic [3:0] base);
        rf_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_rd    = base + 4'(k);
            in_data  = 16'hF000 + 16'(k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        load3(4'd7);
        chk_reg1 = 4'd8;
        #1;
        vectors++;
        if (count !== 3'd3 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: count=%0d hazard=%b want 3/1", count, hazard);
        end
        rf_hold = 1'b0;
        flush   = 1'b1;
        dut_log.delete();
        #1;
        vectors++;
        if (rf_reg_write !== 2'b00 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: rw=%b ready=%b want 00/0",
                     rf_reg_write, in_ready);
        end
        tick();
        flush = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd0 || hazard !== 1'b0 || rf_reg_write !== 2'b00 ||
            dut_log.size() != 0) begin
            errors++;
            $display("FAIL flush_post: count=%0d hazard=%b rw=%b writes=%0d want 0/0/00/0",
                     count, hazard, rf_reg_write, dut_log.size());
        end
        chk_reg1 = '0;
    endtask

    task automatic test_reset_mid();
        load3(4'd2);
        rf_hold = 1'b0;
        #1;
        vectors++;
        if (rf_reg_write !== 2'b01 || rf_write_reg !== 4'd2) begin
            errors++;
            $display("FAIL rstmid_pre: rw=%b reg=%0d want 01/2",
                     rf_reg_write, rf_write_reg);
        end
        chk_reg2 = 4'd3;
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (rf_reg_write !== 2'b00 || rf_write_reg !== 4'd0 ||
            rf_write_data !== 16'd0 || count !== 3'd0 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_now: rw=%b reg=%0d data=%h count=%0d hazard=%b want zeros",
                     rf_reg_write, rf_write_reg, rf_write_data, count, hazard);
        end
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_rd    = 4'd9;
        in_data  = 16'h0909;
        rf_hold  = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_enq: count=%0d want 1", count);
        end
        rf_hold = 1'b0;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [1:0]  e_rw;
        logic [3:0]  e_reg;
        logic [15:0] e_data;
        logic [15:0] e_r15;
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_rd       = 4'($urandom);
            in_data     = 16'($urandom);
            in_wr_r15   = 1'($urandom);
            in_r15_data = 16'($urandom);
            rf_hold     = ($urandom_range(0, 9) < 3);
            flush       = ($urandom_range(0, 31) == 0);
            chk_reg1    = 4'($urandom);
            chk_reg2    = 4'($urandom);
            #1;
            e_rw   = 2'b00;
            e_reg  = '0;
            e_data = '0;
            e_r15  = '0;
            if (q.size() > 0 && !rf_hold && !flush) begin
                e_rw   = q[0].wr ? 2'b10 : 2'b01;
                e_reg  = q[0].rd;
                e_data = q[0].data;
                e_r15  = q[0].wr ? q[0].r15 : 16'd0;
            end
            vectors++;
            if (in_ready !== ((q.size() < DEPTH) && !flush) ||
                count !== 3'(q.size()) || hazard !== m_hazard()) begin
                errors++;
                $display("FAIL rand_status_%0d: ready=%b count=%0d hazard=%b want count=%0d hazard=%b",
                         c, in_ready, count, hazard, q.size(), m_hazard());
            end
            vectors++;
            if (rf_reg_write !== e_rw || rf_write_reg !== e_reg ||
                rf_write_data !== e_data || rf_write_r15 !== e_r15) begin
                errors++;
                $display("FAIL rand_rf_%0d: rw=%b reg=%0d data=%h r15=%h want %b/%0d/%h/%h",
                         c, rf_reg_write, rf_write_reg, rf_write_data,
                         rf_write_r15, e_rw, e_reg, e_data, e_r15);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_fill();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
